// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the M stage: access FSM encoding and result-source encoding.
package memory_cycle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_state_e;

    localparam logic RESULT_SRC_ALU = 1'b0;
    localparam logic RESULT_SRC_MEM = 1'b1;

    function automatic logic is_mem_op(input logic mem_write, input logic result_src);
        return mem_write | (result_src == RESULT_SRC_MEM);
    endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory port: valid/ready request channel plus a response-valid read-data channel.
interface memory_cycle_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/memory_cycle_mw_pipe_reg.sv
// M/W pipeline register: captures M-stage fields when not stalled, inserts a bubble otherwise.
module memory_cycle_mw_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              load_rd,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_W-1:0]  RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] ALU_ResultM,
    input  logic [DATA_W-1:0] rdata,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_W-1:0]  RD_W,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
        end else if (stall) begin
            // Bubble: only the write enable is killed, payload fields hold.
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            if (load_rd)
                ReadDataW <= rdata;
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// M stage of the RV32 pipeline: issues data-memory accesses, stalls upstream while one is
// outstanding, and feeds the M/W pipeline register.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_W-1:0]  RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] ALU_ResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallM,
    memory_cycle_if.master    dmem,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_W-1:0]  RD_W,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW
);

    mem_state_e state;
    logic       mem_op;
    logic       req_valid;
    logic       accept;
    logic       load_rd;
    logic       done;
    logic       stall;

    // Gated by rst so valid and stall drop the instant reset asserts, even mid-access.
    always_comb begin
        mem_op    = is_mem_op(MemWriteM, ResultSrcM);
        req_valid = rst & (((state == IDLE) & mem_op) | (state == REQ));
        accept    = req_valid & dmem.req_ready;
        load_rd   = rst & (state == RSP) & dmem.rsp_valid;
        done      = (accept & MemWriteM) | load_rd;
        stall     = rst & mem_op & ~done;
    end

    assign dmem.req_valid = req_valid;
    assign dmem.req_we    = MemWriteM;
    assign dmem.req_addr  = ALU_ResultM;
    assign dmem.req_wdata = WriteDataM;
    assign StallM         = stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (mem_op)
                             state <= !dmem.req_ready ? REQ : (MemWriteM ? IDLE : RSP);
                REQ:     if (dmem.req_ready)
                             state <= MemWriteM ? IDLE : RSP;
                RSP:     if (dmem.rsp_valid)
                             state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    memory_cycle_mw_pipe_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mw_pipe_reg (
        .clk         (clk),
        .rst_n       (rst),
        .stall       (stall),
        .load_rd     (load_rd),
        .RegWriteM   (RegWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .ALU_ResultM (ALU_ResultM),
        .rdata       (dmem.rsp_rdata),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW)
    );

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: transaction-level model checked every negedge plus
// hand-computed literal expectations for each scenario.
module tb_memory_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    memory_cycle_if #(.DATA_W(32)) dmem ();

    memory_cycle #(.DATA_W(32), .REG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .StallM      (StallM),
        .dmem        (dmem),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit sim_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
        PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
    endtask

    // Model: an access is either unsent/unaccepted or (for loads) accepted and awaiting data.
    task automatic model_loop();
        logic        m_wait = 0;
        logic        m_rw = 0, m_rs = 0;
        logic [4:0]  m_rd = 0;
        logic [31:0] m_pc = 0, m_alu = 0, m_rdata = 0;
        logic        memop, exp_valid, accepted, finished, exp_stall;
        while (!sim_done) begin
            @(negedge clk);
            if (!rst) begin
                m_wait = 0; m_rw = 0; m_rs = 0; m_rd = 0;
                m_pc = 0; m_alu = 0; m_rdata = 0;
            end
            chk("m_RegWriteW", RegWriteW, m_rw);
            chk("m_ResultSrcW", ResultSrcW, m_rs);
            chk("m_RD_W", RD_W, m_rd);
            chk("m_PCPlus4W", PCPlus4W, m_pc);
            chk("m_ALU_ResultW", ALU_ResultW, m_alu);
            chk("m_ReadDataW", ReadDataW, m_rdata);
            memop     = MemWriteM | ResultSrcM;
            exp_valid = rst & memop & !m_wait;
            accepted  = exp_valid & dmem.req_ready;
            finished  = (MemWriteM & accepted) | (m_wait & dmem.rsp_valid);
            exp_stall = rst & memop & !finished;
            chk("m_req_valid", dmem.req_valid, exp_valid);
            chk("m_StallM", StallM, exp_stall);
            if (exp_valid) begin
                chk("m_req_we", dmem.req_we, MemWriteM);
                chk("m_req_addr", dmem.req_addr, ALU_ResultM);
                chk("m_req_wdata", dmem.req_wdata, WriteDataM);
            end
            if (rst) begin
                if (!exp_stall) begin
                    m_rw = RegWriteM; m_rs = ResultSrcM; m_rd = RD_M;
                    m_pc = PCPlus4M; m_alu = ALU_ResultM;
                    if (m_wait) m_rdata = dmem.rsp_rdata;
                    m_wait = 0;
                end else begin
                    m_rw = 0;
                    if (accepted && !MemWriteM) m_wait = 1;
                end
            end
        end
    endtask

    task automatic stimulus();
        int stall_cnt;
        // 1. reset
        #3;
        chk("rst_RegWriteW", RegWriteW, 0);
        chk("rst_ALU_ResultW", ALU_ResultW, 0);
        chk("rst_ReadDataW", ReadDataW, 0);
        chk("rst_req_valid", dmem.req_valid, 0);
        chk("rst_StallM", StallM, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // 2. ALU op passes through with latency 1
        set_m(1, 0, 0, 5'd1, 32'd4, 32'd8, 32'd0);
        #1;
        chk("alu_req_valid", dmem.req_valid, 0);
        chk("alu_StallM", StallM, 0);
        tick();
        chk("alu_ALU_ResultW", ALU_ResultW, 32'd8);
        chk("alu_RD_W", RD_W, 5'd1);
        chk("alu_RegWriteW", RegWriteW, 1);

        // 3. store, zero-wait
        dmem.req_ready = 1'b1;
        set_m(0, 1, 0, 5'd0, 32'd8, 32'h1C, 32'hAABBCCDD);
        #1;
        chk("st_req_valid", dmem.req_valid, 1);
        chk("st_req_we", dmem.req_we, 1);
        chk("st_req_addr", dmem.req_addr, 32'h1C);
        chk("st_req_wdata", dmem.req_wdata, 32'hAABBCCDD);
        chk("st_StallM", StallM, 0);
        tick();
        chk("st_RegWriteW", RegWriteW, 0);
        set_m(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();

        // 4. load: ready low 2 cycles, response 3 cycles after acceptance
        set_m(1, 0, 1, 5'd3, 32'h40, 32'h14, 32'd0);
        dmem.rsp_rdata = 32'h12345678;
        stall_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            dmem.req_ready = (c == 2);
            dmem.rsp_valid = (c == 5);
            #1;
            if (StallM) stall_cnt++;
            if (c >= 1) chk("ld_bubble_RegWriteW", RegWriteW, 0);
            tick();
        end
        dmem.rsp_valid = 1'b0;
        dmem.req_ready = 1'b1;
        chk("ld_stall_cycles", stall_cnt, 5);
        chk("ld_ReadDataW", ReadDataW, 32'h12345678);
        chk("ld_ResultSrcW", ResultSrcW, 1);
        chk("ld_RegWriteW", RegWriteW, 1);
        chk("ld_RD_W", RD_W, 5'd3);
        set_m(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();

        // 5. reset while waiting for load data; late response ignored
        set_m(1, 0, 1, 5'd7, 32'h60, 32'h20, 32'd0);
        tick();
        #1;
        chk("rr_StallM_before", StallM, 1);
        rst = 1'b0;
        #1;
        chk("rr_req_valid", dmem.req_valid, 0);
        chk("rr_StallM", StallM, 0);
        chk("rr_ReadDataW", ReadDataW, 0);
        set_m(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        dmem.rsp_valid = 1'b1;
        dmem.rsp_rdata = 32'hDEADBEEF;
        tick();
        dmem.rsp_valid = 1'b0;
        chk("rr_late_ReadDataW", ReadDataW, 0);
        chk("rr_late_RegWriteW", RegWriteW, 0);

        // 6. load then ADD back-to-back, zero-wait memory
        set_m(1, 0, 1, 5'd4, 32'h50, 32'h30, 32'd0);
        tick();
        dmem.rsp_valid = 1'b1;
        dmem.rsp_rdata = 32'hCAFEF00D;
        tick();
        dmem.rsp_valid = 1'b0;
        chk("b2b_ld_RD_W", RD_W, 5'd4);
        chk("b2b_ld_ReadDataW", ReadDataW, 32'hCAFEF00D);
        chk("b2b_ld_ResultSrcW", ResultSrcW, 1);
        chk("b2b_ld_RegWriteW", RegWriteW, 1);
        set_m(1, 0, 0, 5'd2, 32'h54, 32'd5, 32'd0);
        tick();
        chk("b2b_add_ALU_ResultW", ALU_ResultW, 32'd5);
        chk("b2b_add_RD_W", RD_W, 5'd2);
        chk("b2b_add_ResultSrcW", ResultSrcW, 0);
        chk("b2b_add_ReadDataW", ReadDataW, 32'hCAFEF00D);
        set_m(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        sim_done = 1;
    endtask

    initial begin
        rst = 1'b0;
        set_m(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        dmem.req_ready = 1'b0;
        dmem.rsp_valid = 1'b0;
        dmem.rsp_rdata = 32'd0;
        fork
            model_loop();
            stimulus();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
